// File: rtl/dmem_mmio_responder_if.sv
// Bus bundle between the CPU data port, DATA_MEMORY, the output stream sink
// and the MMIO responder.
interface dmem_mmio_responder_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  // CPU side
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  // RAM side
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  // Output stream: a word transfers on any edge where out_valid & out_ready.
  // out_valid never depends on out_ready; out_data holds while not accepted.
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport slave (
    input  we, addr, din, ram_dout, out_ready,
    output dout, ram_we, ram_addr, ram_din, out_valid, out_data
  );

  modport master (
    output we, addr, din, ram_dout, out_ready,
    input  dout, ram_we, ram_addr, ram_din, out_valid, out_data
  );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: passes CPU accesses through to RAM except for a
// 16-byte MMIO window holding an output FIFO, status, cycle counter and scratch.
module dmem_mmio_responder #(
  parameter int              ADDR_W     = 9,
  parameter int              DATA_W     = 32,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 9'h1F0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  dmem_mmio_responder_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] OFF_OUTDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_CYCLE   = 2'd2;
  localparam logic [1:0] OFF_SCRATCH = 2'd3;

  logic              hit;
  logic [1:0]        off;
  logic              we_eff;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              accept;
  logic              drop;
  logic              ovf_clr;
  logic              cycle_clr;
  logic              scratch_we;
  logic [3:0]        count4;
  logic [DATA_W-1:0] rd_mux;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic [31:0]       cycle_cnt;
  logic [DATA_W-1:0] scratch;
  logic              hit_q;
  logic [DATA_W-1:0] mmio_q;

  assign hit    = (bus.addr[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4]);
  assign off    = bus.addr[3:2];
  // Writes are ignored entirely while reset is held.
  assign we_eff = bus.we & ~rst;

  assign bus.ram_we   = we_eff & ~hit;
  assign bus.ram_addr = bus.addr;
  assign bus.ram_din  = bus.din;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(FIFO_DEPTH));
  assign push   = we_eff & hit & (off == OFF_OUTDATA);
  assign pop    = bus.out_valid & bus.out_ready;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  assign ovf_clr    = we_eff & hit & (off == OFF_STATUS) & bus.din[2];
  assign cycle_clr  = we_eff & hit & (off == OFF_CYCLE);
  assign scratch_we = we_eff & hit & (off == OFF_SCRATCH);

  assign bus.out_valid = ~empty;
  assign bus.out_data  = mem[rd_ptr];

  assign count4 = 4'(count);

  // Status byte: count in [7:4], bit 3 reserved, then ovf/empty/full.
  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_OUTDATA: rd_mux = '0;
      OFF_STATUS:  rd_mux = DATA_W'({count4, 1'b0, ovf, empty, full});
      OFF_CYCLE:   rd_mux = DATA_W'(cycle_cnt);
      OFF_SCRATCH: rd_mux = scratch;
      default:     rd_mux = '0;
    endcase
  end

  // Storage is not reset; emptiness is carried by count alone.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf       <= 1'b0;
      cycle_cnt <= '0;
      scratch   <= '0;
    end else begin
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      cycle_cnt <= cycle_clr ? 32'd0 : cycle_cnt + 32'd1;
      if (scratch_we) scratch <= bus.din;
    end
  end

  // Read data is captured from pre-write state, matching RAM read-before-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= 1'b0;
      mmio_q <= '0;
    end else begin
      hit_q  <= hit;
      mmio_q <= rd_mux;
    end
  end

  assign bus.dout = hit_q ? mmio_q : bus.ram_dout;
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed plus randomized bench for dmem_mmio_responder against a queue-based
// model of the MMIO window and a word-array model of RAM.
module tb_dmem_mmio_responder;
  localparam int DEPTH = 4;
  localparam logic [8:0] A_OUT  = 9'h1F0;
  localparam logic [8:0] A_STAT = 9'h1F4;
  localparam logic [8:0] A_CYC  = 9'h1F8;
  localparam logic [8:0] A_SCR  = 9'h1FC;

  logic clk = 1'b0;
  logic rst;

  dmem_mmio_responder_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  dmem_mmio_responder #(
    .ADDR_W(9), .DATA_W(32), .MMIO_BASE(9'h1F0), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  // DATA_MEMORY stand-in: synchronous read, read-before-write.
  logic [31:0] ram_arr [128] = '{default: '0};
  logic [31:0] ram_rd = '0;
  always @(posedge clk) begin
    if (bus.ram_we) ram_arr[bus.ram_addr[8:2]] <= bus.ram_din;
    ram_rd <= ram_arr[bus.ram_addr[8:2]];
  end
  assign bus.ram_dout = ram_rd;

  // reference model state
  logic [31:0] exp_q [$];
  logic [31:0] exp_ram [128] = '{default: '0};
  logic        m_ovf;
  logic [31:0] m_cyc;
  logic [31:0] m_scr;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_dout;
  logic [31:0] last_odata;
  logic        last_ovalid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [3:0] n;
    n = 4'(exp_q.size());
    return {24'b0, n, 1'b0, m_ovf, (exp_q.size() == 0), (exp_q.size() == DEPTH)};
  endfunction

  // driver: one bus cycle, checked against the model
  task automatic step(input bit r, input bit w, input logic [8:0] a,
                      input logic [31:0] d, input bit rdy);
    bit          hit;
    logic [1:0]  off;
    logic [31:0] exp_rd;
    bit          popped;
    bit          was_full;
    bit          drop;
    @(negedge clk);
    rst = r; bus.we = w; bus.addr = a; bus.din = d; bus.out_ready = rdy;
    #1;
    hit = (a[8:4] == 5'h1F);
    off = a[3:2];
    last_ovalid = bus.out_valid;
    last_odata  = bus.out_data;
    check("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) check("out_data", bus.out_data, exp_q[0]);
    check("ram_we", {31'b0, bus.ram_we}, {31'b0, w & !r & !hit});
    check("ram_addr", {23'b0, bus.ram_addr}, {23'b0, a});

    if (r || !hit) exp_rd = exp_ram[a[8:2]];
    else begin
      case (off)
        2'd0: exp_rd = 32'h0;
        2'd1: exp_rd = m_status();
        2'd2: exp_rd = m_cyc;
        default: exp_rd = m_scr;
      endcase
    end

    if (r) begin
      exp_q.delete();
      m_ovf = 1'b0; m_cyc = 32'h0; m_scr = 32'h0;
    end else begin
      was_full = (exp_q.size() == DEPTH);
      popped   = (exp_q.size() != 0) && rdy;
      drop     = w && hit && off == 2'd0 && was_full && !popped;
      if (popped) void'(exp_q.pop_front());
      if (w && hit && off == 2'd0 && !drop) exp_q.push_back(d);
      if (drop) m_ovf = 1'b1;
      else if (w && hit && off == 2'd1 && d[2]) m_ovf = 1'b0;
      m_cyc = (w && hit && off == 2'd2) ? 32'h0 : m_cyc + 32'h1;
      if (w && hit && off == 2'd3) m_scr = d;
      if (w && !hit) exp_ram[a[8:2]] = d;
    end

    @(posedge clk);
    #1;
    last_dout = bus.dout;
    check("dout", bus.dout, exp_rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] c0;
  logic [8:0]  ra;
  int          sel;

  initial begin
    rst = 1'b1; bus.we = 1'b0; bus.addr = '0; bus.din = '0; bus.out_ready = 1'b0;
    exp_q.delete(); m_ovf = 1'b0; m_cyc = 32'h0; m_scr = 32'h0;
    repeat (2) @(posedge clk);

    // reset state
    step(1, 0, A_STAT, 0, 0);
    step(0, 0, A_STAT, 0, 0);
    check("t1_status_reset", last_dout, 32'h0000_0002);
    step(0, 0, A_CYC, 0, 0);
    c0 = last_dout;
    step(0, 0, A_CYC, 0, 0);
    check("t1_cycle_incr", last_dout - c0, 32'd1);

    // RAM path and window writes not reaching RAM
    step(0, 1, 9'h010, 32'hDEAD_BEEF, 0);
    step(0, 0, 9'h010, 0, 0);
    check("t2_ram_read", last_dout, 32'hDEAD_BEEF);
    step(0, 1, A_SCR, 32'h1234_5678, 0);
    step(0, 0, A_SCR, 0, 0);
    check("t2_scratch", last_dout, 32'h1234_5678);

    // overfill with sink stalled, then drain
    for (int i = 1; i <= 5; i++) step(0, 1, A_OUT, i, 0);
    step(0, 0, A_STAT, 0, 0);
    check("t3_status_full_ovf", last_dout, 32'h0000_0045);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 9'h020, 0, 1);
      check("t3_drain", last_odata, i);
    end
    step(0, 0, A_STAT, 0, 0);
    check("t3_drained_valid", {31'b0, last_ovalid}, 32'h0);

    // clear ovf
    step(0, 1, A_STAT, 32'h4, 0);
    step(0, 0, A_STAT, 0, 0);
    check("t5_ovf_clear", last_dout, 32'h0000_0002);

    // push into full FIFO while popping
    for (int i = 0; i < 4; i++) step(0, 1, A_OUT, 32'h10 + i, 0);
    step(0, 1, A_OUT, 32'hA5, 1);
    step(0, 0, A_STAT, 0, 0);
    check("t4_status_no_ovf", last_dout, 32'h0000_0041);
    for (int i = 0; i < 4; i++) step(0, 0, 9'h024, 0, 1);
    check("t4_a5_last", last_odata, 32'hA5);
    step(0, 0, A_STAT, 0, 0);
    check("t4_empty", last_dout, 32'h0000_0002);

    // cycle counter clear and wrap
    step(0, 1, A_CYC, 32'hFFFF_FFFF, 0);
    step(0, 0, A_CYC, 0, 0);
    check("t5_cycle_clear", last_dout, 32'h0);
    step(0, 0, A_CYC, 0, 0);
    check("t5_cycle_after_clear", last_dout, 32'h1);
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_cnt;
    m_cyc = 32'hFFFF_FFFE;
    step(0, 0, A_CYC, 0, 0);
    step(0, 0, A_CYC, 0, 0);
    check("t5_cycle_max", last_dout, 32'hFFFF_FFFF);
    step(0, 0, A_CYC, 0, 0);
    check("t5_cycle_wrap", last_dout, 32'h0);

    // reset mid-stream
    for (int i = 0; i < 3; i++) step(0, 1, A_OUT, 32'h100 + i, 0);
    step(1, 1, A_OUT, 32'hBAD, 0);
    step(0, 0, A_SCR, 0, 0);
    check("t6_valid_after_rst", {31'b0, last_ovalid}, 32'h0);
    check("t6_scratch_rst", last_dout, 32'h0);
    step(0, 1, A_OUT, 32'h777, 0);
    step(0, 0, A_STAT, 0, 1);
    check("t6_fresh_word", last_odata, 32'h777);
    check("t6_fresh_count", last_dout, 32'h0000_0010);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 9);
      ra  = {2'b0, 5'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      case (sel)
        0, 1, 2: ra = {A_OUT[8:4], 2'd0, 2'($urandom_range(0, 3))};
        3:       ra = A_STAT;
        4:       ra = A_CYC;
        5:       ra = A_SCR;
        default: ;
      endcase
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 1) == 1), ra,
           (sel == 3) ? 32'($urandom_range(0, 7)) : $urandom,
           ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
